// File: rtl/pry2oht_pkg.sv
// Shared constants, FSM state type and one-hot helper functions for the
// pry2oht arbiter family.
package pry2oht_pkg;

   localparam logic DIR_LSB = 1'b0;
   localparam logic DIR_MSB = 1'b1;

   // Helper functions operate on a fixed maximum width; callers size-cast.
   localparam int MAX_W = 64;

   typedef enum logic {IDLE, GRANT} state_t;

   // One-hot to binary index; shifts instead of variable bit selects.
   function automatic int oht2idx(input logic [MAX_W-1:0] oht);
      logic [MAX_W-1:0] tmp;
      int               idx;
      tmp = oht;
      idx = 0;
      for (int i = 0; i < MAX_W; i++) begin
         if (tmp[0]) idx = idx | i;
         tmp = tmp >> 1;
      end
      return idx;
   endfunction

   // One-hot grant k to the rotating priority mask. LSB: bits above k set.
   // MSB: bits below k set. The end bit yields all-zero, which hands
   // selection to the unmasked path (wrap-around).
   function automatic logic [MAX_W-1:0] oht2msk(input logic [MAX_W-1:0] oht,
                                                input logic             dir);
      if (dir == DIR_LSB) return ~((oht << 1) - MAX_W'(1));
      else                return oht - MAX_W'(1);
   endfunction

endpackage

// File: rtl/pry2oht_tree.sv
// Priority-to-one-hot converter. IMPLEMENTATION 0 is a two-level tree
// (groups of SPLIT bits, then a bit within the winning group);
// any other value is a flat ripple chain. DIRECTION picks the winning end.
module pry2oht_tree
   import pry2oht_pkg::*;
#(
   parameter int   WIDTH          = 8,
   parameter int   SPLIT          = 2,
   parameter logic DIRECTION      = DIR_LSB,
   parameter int   IMPLEMENTATION = 0
) (
   input  logic [WIDTH-1:0] pry,
   output logic [WIDTH-1:0] oht
);

   if (IMPLEMENTATION == 0) begin : g_tree
      localparam int NG = WIDTH / SPLIT;
      logic [NG-1:0]    grp_any, grp_lo, grp_hi, grp_sel;
      logic [WIDTH-1:0] bit_lo, bit_hi;

      for (genvar g = 0; g < NG; g++) begin : g_grp
         assign grp_any[g] = |pry[g*SPLIT +: SPLIT];
         // grp_lo/grp_hi: any request in a group strictly below/above g
         if (g == 0) begin : g_lo0
            assign grp_lo[g] = 1'b0;
         end else begin : g_lon
            assign grp_lo[g] = grp_lo[g-1] | grp_any[g-1];
         end
         if (g == NG-1) begin : g_hi0
            assign grp_hi[g] = 1'b0;
         end else begin : g_hin
            assign grp_hi[g] = grp_hi[g+1] | grp_any[g+1];
         end
         assign grp_sel[g] = grp_any[g] &
                             ~((DIRECTION == DIR_LSB) ? grp_lo[g] : grp_hi[g]);

         for (genvar t = 0; t < SPLIT; t++) begin : g_bit
            localparam int B = g*SPLIT + t;
            // in-group chains restart at each group boundary
            if (t == 0) begin : g_blo0
               assign bit_lo[B] = 1'b0;
            end else begin : g_blon
               assign bit_lo[B] = bit_lo[B-1] | pry[B-1];
            end
            if (t == SPLIT-1) begin : g_bhi0
               assign bit_hi[B] = 1'b0;
            end else begin : g_bhin
               assign bit_hi[B] = bit_hi[B+1] | pry[B+1];
            end
            assign oht[B] = grp_sel[g] & pry[B] &
                            ~((DIRECTION == DIR_LSB) ? bit_lo[B] : bit_hi[B]);
         end
      end
   end else begin : g_flat
      logic [WIDTH-1:0] lo, hi;
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (i == 0) begin : g_lo0
            assign lo[i] = 1'b0;
         end else begin : g_lon
            assign lo[i] = lo[i-1] | pry[i-1];
         end
         if (i == WIDTH-1) begin : g_hi0
            assign hi[i] = 1'b0;
         end else begin : g_hin
            assign hi[i] = hi[i+1] | pry[i+1];
         end
         assign oht[i] = pry[i] & ~((DIRECTION == DIR_LSB) ? lo[i] : hi[i]);
      end
   end

endmodule

// File: rtl/pry2oht_rr.sv
// Registered round-robin arbiter: rotating priority mask, valid/ready grant
// handshake and optional multi-beat grant locking. Supports WIDTH up to MAX_W.
module pry2oht_rr
   import pry2oht_pkg::*;
#(
   parameter  int   WIDTH          = 8,
   parameter  int   SPLIT          = 2,
   parameter  logic DIRECTION      = DIR_LSB,
   parameter  int   IMPLEMENTATION = 0,
   parameter  logic LOCK           = 1'b0,
   localparam int   WIDTH_LOG      = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     req,
   output logic [WIDTH-1:0]     gnt,
   output logic                 gnt_vld,
   input  logic                 gnt_rdy,
   input  logic                 lst,
   output logic [WIDTH_LOG-1:0] gnt_idx
);

   state_t           state;
   logic [WIDTH-1:0] msk, msk_nxt, req_msk, sel_msk, sel_raw, sel;
   logic             rel;

   // A release updates the mask in the same cycle, so the follow-on grant
   // is chosen from the post-release mask with no bubble.
   assign rel     = (state == GRANT) && gnt_rdy && (!LOCK || lst);
   assign msk_nxt = rel ? WIDTH'(oht2msk(MAX_W'(gnt), DIRECTION)) : msk;
   assign req_msk = req & msk_nxt;
   assign sel     = (|req_msk) ? sel_msk : sel_raw;

   pry2oht_tree #(
      .WIDTH(WIDTH), .SPLIT(SPLIT), .DIRECTION(DIRECTION),
      .IMPLEMENTATION(IMPLEMENTATION)
   ) u_tree_msk (
      .pry(req_msk),
      .oht(sel_msk)
   );

   pry2oht_tree #(
      .WIDTH(WIDTH), .SPLIT(SPLIT), .DIRECTION(DIRECTION),
      .IMPLEMENTATION(IMPLEMENTATION)
   ) u_tree_raw (
      .pry(req),
      .oht(sel_raw)
   );

   // Grant FSM: issue from IDLE, hold in GRANT until release, then chain or idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         gnt     <= '0;
         gnt_vld <= 1'b0;
         gnt_idx <= '0;
         msk     <= '1;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  gnt     <= sel;
                  gnt_idx <= WIDTH_LOG'(oht2idx(MAX_W'(sel)));
                  gnt_vld <= 1'b1;
                  state   <= GRANT;
               end
            end
            GRANT: begin
               if (rel) begin
                  msk <= msk_nxt;
                  if (|sel) begin
                     gnt     <= sel;
                     gnt_idx <= WIDTH_LOG'(oht2idx(MAX_W'(sel)));
                  end else begin
                     gnt     <= '0;
                     gnt_idx <= '0;
                     gnt_vld <= 1'b0;
                     state   <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pry2oht_rr.sv
// Bench for pry2oht_rr: three instances (LSB/no-lock, LSB/lock, MSB/no-lock),
// table-driven vectors plus hand-written multi-cycle sequences, all checked
// through an expected-value queue.
module tb_pry2oht_rr;
   import pry2oht_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_v [3];
   logic [7:0] req_v [3];
   logic       rdy_v [3];
   logic       lst_v [3];
   logic [7:0] gnt_v [3];
   logic       vld_v [3];
   logic [2:0] idx_v [3];

   pry2oht_rr #(.WIDTH(8), .SPLIT(2), .DIRECTION(DIR_LSB), .IMPLEMENTATION(0), .LOCK(1'b0))
   u_lsb (.clk(clk), .rst(rst_v[0]), .req(req_v[0]), .gnt(gnt_v[0]), .gnt_vld(vld_v[0]),
          .gnt_rdy(rdy_v[0]), .lst(lst_v[0]), .gnt_idx(idx_v[0]));

   pry2oht_rr #(.WIDTH(8), .SPLIT(2), .DIRECTION(DIR_LSB), .IMPLEMENTATION(0), .LOCK(1'b1))
   u_lck (.clk(clk), .rst(rst_v[1]), .req(req_v[1]), .gnt(gnt_v[1]), .gnt_vld(vld_v[1]),
          .gnt_rdy(rdy_v[1]), .lst(lst_v[1]), .gnt_idx(idx_v[1]));

   pry2oht_rr #(.WIDTH(8), .SPLIT(2), .DIRECTION(DIR_MSB), .IMPLEMENTATION(0), .LOCK(1'b0))
   u_msb (.clk(clk), .rst(rst_v[2]), .req(req_v[2]), .gnt(gnt_v[2]), .gnt_vld(vld_v[2]),
          .gnt_rdy(rdy_v[2]), .lst(lst_v[2]), .gnt_idx(idx_v[2]));

   typedef struct {
      int         d;
      logic       rst;
      logic [7:0] req;
      logic       rdy;
      logic       lst;
      logic [7:0] gnt;
      logic       vld;
   } vec_t;

   typedef struct {
      int         d;
      logic [7:0] gnt;
      logic       vld;
      logic [2:0] idx;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference index of a one-hot (or zero) grant.
   function automatic logic [2:0] exp_idx(input logic [7:0] g);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 8; i++)
         if (g == (8'h01 << i)) r = 3'(i);
      return r;
   endfunction

   task automatic cmp(input string nm, input int step, input logic [7:0] act,
                      input logic [7:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s step %0d: got %h expected %h", nm, step, act, req);
      end
   endtask

   // Pop the oldest expectation and compare it with the DUT it belongs to.
   task automatic check_out(input int step);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL sb_empty step %0d: got 0 entries expected 1", step);
      end else begin
         e = sb.pop_front();
         cmp("gnt", step, gnt_v[e.d], e.gnt);
         cmp("gnt_vld", step, {7'd0, vld_v[e.d]}, {7'd0, e.vld});
         cmp("gnt_idx", step, {5'd0, idx_v[e.d]}, {5'd0, e.idx});
      end
   endtask

   // Drive one cycle of inputs (at negedge), push the expected post-edge
   // outputs, then sample at the following negedge.
   task automatic drive(input int d, input logic r, input logic [7:0] rq,
                        input logic rdy, input logic l,
                        input logic [7:0] eg, input logic ev, input int step);
      exp_t e;
      rst_v[d] = r;
      req_v[d] = rq;
      rdy_v[d] = rdy;
      lst_v[d] = l;
      e.d   = d;
      e.gnt = eg;
      e.vld = ev;
      e.idx = exp_idx(eg);
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      check_out(step);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst_v[i] = 1'b1;
         req_v[i] = 8'h00;
         rdy_v[i] = 1'b0;
         lst_v[i] = 1'b0;
      end
      @(negedge clk);

      // reset / sweep / sparse-wrap / idle / backpressure on the LSB instance
      tbl.push_back('{0, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0});
      for (int i = 0; i < 8; i++)
         tbl.push_back('{0, 1'b0, 8'hFF, 1'b1, 1'b0, 8'(8'h01 << i), 1'b1});
      tbl.push_back('{0, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h01, 1'b1});
      tbl.push_back('{0, 1'b1, 8'h91, 1'b1, 1'b0, 8'h00, 1'b0});
      tbl.push_back('{0, 1'b0, 8'h91, 1'b1, 1'b0, 8'h01, 1'b1});
      tbl.push_back('{0, 1'b0, 8'h91, 1'b1, 1'b0, 8'h10, 1'b1});
      tbl.push_back('{0, 1'b0, 8'h91, 1'b1, 1'b0, 8'h80, 1'b1});
      tbl.push_back('{0, 1'b0, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1});
      tbl.push_back('{0, 1'b0, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1});
      tbl.push_back('{0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0});
      tbl.push_back('{0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0});
      tbl.push_back('{0, 1'b0, 8'h04, 1'b0, 1'b0, 8'h04, 1'b1});
      tbl.push_back('{0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h04, 1'b1});
      tbl.push_back('{0, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h04, 1'b1});
      tbl.push_back('{0, 1'b0, 8'h0B, 1'b0, 1'b0, 8'h04, 1'b1});
      tbl.push_back('{0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h04, 1'b1});
      tbl.push_back('{0, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h04, 1'b1});
      tbl.push_back('{0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0});

      foreach (tbl[i])
         drive(tbl[i].d, tbl[i].rst, tbl[i].req, tbl[i].rdy, tbl[i].lst,
               tbl[i].gnt, tbl[i].vld, i);

      // locked transfer: grant 02 held over lst=0,0,1 then moves to 04
      drive(1, 1'b1, 8'h06, 1'b0, 1'b0, 8'h00, 1'b0, 100);
      drive(1, 1'b0, 8'h06, 1'b0, 1'b0, 8'h02, 1'b1, 101);
      drive(1, 1'b0, 8'h06, 1'b1, 1'b0, 8'h02, 1'b1, 102);
      drive(1, 1'b0, 8'h06, 1'b1, 1'b0, 8'h02, 1'b1, 103);
      drive(1, 1'b0, 8'h06, 1'b1, 1'b1, 8'h04, 1'b1, 104);
      drive(1, 1'b0, 8'h06, 1'b1, 1'b1, 8'h02, 1'b1, 105);

      // MSB sweep with wrap, then reset mid-grant restores the full mask
      drive(2, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 200);
      for (int i = 0; i < 9; i++)
         drive(2, 1'b0, 8'hFF, 1'b1, 1'b0, (i == 8) ? 8'h80 : 8'(8'h80 >> i), 1'b1, 201 + i);
      drive(2, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h40, 1'b1, 210);
      drive(2, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 211);
      drive(2, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h80, 1'b1, 212);

      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: got %0d entries expected 0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
